// File: rtl/gtfraw_vnc_prbs_err_mon.sv
// PRBS error monitor: lock/loss FSM plus saturating word, bit and loss counters.
// Three-stage pipe: capture, popcount, FSM and statistics update.
module gtfraw_vnc_prbs_err_mon #(
  parameter int NBITS      = 16,
  parameter int LOCK_CNT   = 64,
  parameter int UNLOCK_CNT = 4,
  parameter int CNT_W      = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NBITS-1:0] ERR_IN,
  input  logic             EN,
  input  logic             CLR,
  output logic             LOCKED,
  output logic             LOCK_LOST,
  output logic [CNT_W-1:0] WORD_CNT,
  output logic [CNT_W-1:0] WORD_ERR_CNT,
  output logic [CNT_W-1:0] BIT_ERR_CNT,
  output logic [CNT_W-1:0] LOSS_CNT
);

  localparam int PW = $clog2(NBITS + 1);
  localparam logic [15:0] LC = 16'(LOCK_CNT);
  localparam logic [15:0] UC = 16'(UNLOCK_CNT);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  typedef enum logic {
    S_SEARCH = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  logic [NBITS-1:0] r_s0_word;
  logic             r_s0_vld;
  logic [PW-1:0]    r_s1_pop;
  logic             r_s1_err;
  logic             r_s1_vld;

  state_t           r_state;
  logic [15:0]      r_clean_run;
  logic [15:0]      r_err_run;
  logic             r_lock_lost;
  logic [CNT_W-1:0] r_word_cnt;
  logic [CNT_W-1:0] r_word_err_cnt;
  logic [CNT_W-1:0] r_bit_err_cnt;
  logic [CNT_W-1:0] r_loss_cnt;

  logic [PW-1:0]    w_pop;
  logic [15:0]      w_clean_nxt;
  logic [15:0]      w_err_nxt;
  logic [CNT_W:0]   w_bit_sum;

  function automatic logic [CNT_W-1:0] f_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + C_ONE;
  endfunction

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NBITS; i++) begin
      w_pop = w_pop + PW'(r_s0_word[i]);
    end
  end

  assign w_clean_nxt = (&r_clean_run) ? r_clean_run
                     : r_clean_run + 16'd1;
  assign w_err_nxt   = (&r_err_run) ? r_err_run
                     : r_err_run + 16'd1;
  assign w_bit_sum   = {1'b0, r_bit_err_cnt}
                     + {{(CNT_W + 1 - PW){1'b0}}, r_s1_pop};

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s0_word <= '0;
      r_s0_vld  <= 1'b0;
      r_s1_pop  <= '0;
      r_s1_err  <= 1'b0;
      r_s1_vld  <= 1'b0;
    end else begin
      r_s0_word <= ERR_IN;
      r_s0_vld  <= EN;
      r_s1_pop  <= w_pop;
      r_s1_err  <= |r_s0_word;
      r_s1_vld  <= r_s0_vld;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state        <= S_SEARCH;
      r_clean_run    <= '0;
      r_err_run      <= '0;
      r_lock_lost    <= 1'b0;
      r_word_cnt     <= '0;
      r_word_err_cnt <= '0;
      r_bit_err_cnt  <= '0;
      r_loss_cnt     <= '0;
    end else begin
      r_lock_lost <= 1'b0;
      if (r_s1_vld) begin
        unique case (r_state)
          S_SEARCH: begin
            if (r_s1_err) begin
              r_clean_run <= '0;
            end else if (w_clean_nxt == LC) begin
              r_state     <= S_LOCKED;
              r_clean_run <= '0;
            end else begin
              r_clean_run <= w_clean_nxt;
            end
          end
          S_LOCKED: begin
            r_word_cnt <= f_inc(r_word_cnt);
            if (r_s1_err) begin
              r_word_err_cnt <= f_inc(r_word_err_cnt);
              r_bit_err_cnt  <= w_bit_sum[CNT_W] ? '1
                              : w_bit_sum[CNT_W-1:0];
              if (w_err_nxt == UC) begin
                r_state     <= S_SEARCH;
                r_err_run   <= '0;
                r_lock_lost <= 1'b1;
                r_loss_cnt  <= f_inc(r_loss_cnt);
              end else begin
                r_err_run <= w_err_nxt;
              end
            end else begin
              r_err_run <= '0;
            end
          end
          default: r_state <= S_SEARCH;
        endcase
      end
      // clear wins over any same-cycle increment
      if (CLR) begin
        r_word_cnt     <= '0;
        r_word_err_cnt <= '0;
        r_bit_err_cnt  <= '0;
        r_loss_cnt     <= '0;
      end
    end
  end

  assign LOCKED       = (r_state == S_LOCKED);
  assign LOCK_LOST    = r_lock_lost;
  assign WORD_CNT     = r_word_cnt;
  assign WORD_ERR_CNT = r_word_err_cnt;
  assign BIT_ERR_CNT  = r_bit_err_cnt;
  assign LOSS_CNT     = r_loss_cnt;

endmodule

// File: tb/tb_gtfraw_vnc_prbs_err_mon.sv
// Bench for gtfraw_vnc_prbs_err_mon: word-level reference model with a
// per-cycle scoreboard, plus directed scenarios and random traffic.
module tb_gtfraw_vnc_prbs_err_mon;

  localparam int NB  = 16;
  localparam int LK  = 64;
  localparam int UL  = 4;
  localparam int CW  = 8;
  localparam int MAX = 255;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          EN  = 1'b0;
  logic          CLR = 1'b0;
  logic [NB-1:0] ERR_IN = '0;
  logic          LOCKED;
  logic          LOCK_LOST;
  logic [CW-1:0] WORD_CNT;
  logic [CW-1:0] WORD_ERR_CNT;
  logic [CW-1:0] BIT_ERR_CNT;
  logic [CW-1:0] LOSS_CNT;

  gtfraw_vnc_prbs_err_mon #(
    .NBITS(NB), .LOCK_CNT(LK), .UNLOCK_CNT(UL), .CNT_W(CW)
  ) dut (
    .CLK(CLK), .RST(RST), .ERR_IN(ERR_IN), .EN(EN), .CLR(CLR),
    .LOCKED(LOCKED), .LOCK_LOST(LOCK_LOST),
    .WORD_CNT(WORD_CNT), .WORD_ERR_CNT(WORD_ERR_CNT),
    .BIT_ERR_CNT(BIT_ERR_CNT), .LOSS_CNT(LOSS_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit lk;
    bit ll;
    int wc;
    int wec;
    int bec;
    int lc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  bit            m_lk;
  bit            m_ll;
  int            m_clean;
  int            m_err;
  int            m_wc, m_wec, m_bec, m_lc;
  bit            pv[2];
  logic [NB-1:0] pw[2];

  function automatic int sat(input int v);
    return (v > MAX) ? MAX : v;
  endfunction

  task automatic m_reset();
    m_lk = 0; m_ll = 0; m_clean = 0; m_err = 0;
    m_wc = 0; m_wec = 0; m_bec = 0; m_lc = 0;
    pv[0] = 0; pv[1] = 0;
  endtask

  task automatic m_word(input bit v, input logic [NB-1:0] w,
                        input bit clr);
    m_ll = 0;
    if (v) begin
      if (!m_lk) begin
        if (w == 0) begin
          m_clean = (m_clean < 65535) ? m_clean + 1 : m_clean;
          if (m_clean == LK) begin
            m_lk = 1;
            m_clean = 0;
          end
        end else begin
          m_clean = 0;
        end
      end else begin
        m_wc = sat(m_wc + 1);
        if (w != 0) begin
          m_wec = sat(m_wec + 1);
          m_bec = sat(m_bec + $countones(w));
          m_err = m_err + 1;
          if (m_err == UL) begin
            m_lk = 0;
            m_err = 0;
            m_ll = 1;
            m_lc = sat(m_lc + 1);
          end
        end else begin
          m_err = 0;
        end
      end
    end
    if (clr) begin
      m_wc = 0; m_wec = 0; m_bec = 0; m_lc = 0;
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge CLK);
    cyc++;
    if (RST) begin
      m_reset();
    end else begin
      m_word(pv[0], pw[0], CLR);
      pv[0] = pv[1]; pw[0] = pw[1];
      pv[1] = EN;    pw[1] = ERR_IN;
    end
    e.lk = m_lk; e.ll = m_ll;
    e.wc = m_wc; e.wec = m_wec; e.bec = m_bec; e.lc = m_lc;
    q.push_back(e);
    #1;
  endtask

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (LOCKED !== e.lk || LOCK_LOST !== e.ll ||
          int'(WORD_CNT) != e.wc || int'(WORD_ERR_CNT) != e.wec ||
          int'(BIT_ERR_CNT) != e.bec || int'(LOSS_CNT) != e.lc) begin
        bad++;
        $display("FAIL sb cyc=%0d got lk=%0d ll=%0d wc=%0d wec=%0d bec=%0d lc=%0d want lk=%0d ll=%0d wc=%0d wec=%0d bec=%0d lc=%0d",
                 cyc, LOCKED, LOCK_LOST, WORD_CNT, WORD_ERR_CNT,
                 BIT_ERR_CNT, LOSS_CNT, e.lk, e.ll, e.wc, e.wec,
                 e.bec, e.lc);
      end
    end
  end

  task automatic dchk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic idle(input int n);
    EN = 0;
    repeat (n) begin
      ERR_IN = NB'($urandom);
      step();
    end
  endtask

  task automatic word(input logic [NB-1:0] w, input int gap);
    EN = 1;
    ERR_IN = w;
    step();
    idle(gap);
  endtask

  task automatic clr_pulse();
    EN = 0;
    CLR = 1;
    step();
    CLR = 0;
  endtask

  task automatic count_run(input int gap, input string nm);
    word(16'h0101, gap);
    repeat (10) word(16'h0000, gap);
    idle(2);
    dchk({nm, "_wc"}, int'(WORD_CNT), 11);
    dchk({nm, "_wec"}, int'(WORD_ERR_CNT), 1);
    dchk({nm, "_bec"}, int'(BIT_ERR_CNT), 2);
    dchk({nm, "_lk"}, int'(LOCKED), 1);
  endtask

  initial begin
    m_reset();
    RST = 1;
    repeat (3) step();
    RST = 0;
    dchk("rst_lk", int'(LOCKED), 0);
    dchk("rst_wc", int'(WORD_CNT), 0);

    // lock acquisition: LOCKED after edge 66
    repeat (LK) word(16'h0000, 0);
    idle(1);
    dchk("lock_e65", int'(LOCKED), 0);
    idle(1);
    dchk("lock_e66", int'(LOCKED), 1);
    dchk("lock_bec", int'(BIT_ERR_CNT), 0);
    dchk("lock_wc", int'(WORD_CNT), 0);

    count_run(0, "cnt");
    clr_pulse();
    count_run(3, "gap");
    clr_pulse();

    // loss of lock
    repeat (3) word(16'hFFFF, 0);
    word(16'h0000, 0);
    repeat (4) word(16'hFFFF, 0);
    idle(1);
    dchk("loss_ll_early", int'(LOCK_LOST), 0);
    idle(1);
    dchk("loss_ll", int'(LOCK_LOST), 1);
    dchk("loss_lk", int'(LOCKED), 0);
    dchk("loss_lc", int'(LOSS_CNT), 1);
    dchk("loss_wec", int'(WORD_ERR_CNT), 7);
    dchk("loss_bec", int'(BIT_ERR_CNT), 112);
    idle(1);
    dchk("loss_ll_end", int'(LOCK_LOST), 0);

    // relock, then reset mid-traffic
    repeat (LK) word(16'h0000, 0);
    idle(2);
    dchk("relock", int'(LOCKED), 1);
    word(16'h0003, 0);
    RST = 1;
    EN = 1;
    repeat (4) begin
      ERR_IN = NB'($urandom);
      step();
    end
    RST = 0;
    dchk("mid_rst_lk", int'(LOCKED), 0);
    dchk("mid_rst_bec", int'(BIT_ERR_CNT), 0);
    dchk("mid_rst_lc", int'(LOSS_CNT), 0);
    repeat (LK - 1) word(16'h0000, 0);
    word(16'h0001, 0);
    repeat (LK - 1) word(16'h0000, 0);
    idle(2);
    dchk("lock_127", int'(LOCKED), 0);
    word(16'h0000, 0);
    idle(2);
    dchk("lock_128", int'(LOCKED), 1);
    dchk("lock_128_bec", int'(BIT_ERR_CNT), 0);

    // saturation of BIT_ERR_CNT while staying locked
    clr_pulse();
    repeat (5) begin
      repeat (3) word(16'hFFFF, 0);
      word(16'h0000, 0);
    end
    idle(2);
    dchk("sat_240", int'(BIT_ERR_CNT), 240);
    repeat (2) begin
      repeat (3) word(16'hFFFF, 0);
      word(16'h0000, 0);
    end
    idle(2);
    dchk("sat_bec", int'(BIT_ERR_CNT), 255);
    dchk("sat_wec", int'(WORD_ERR_CNT), 21);
    dchk("sat_lk", int'(LOCKED), 1);

    // CLR in the S2 cycle of an errored word
    word(16'h000F, 0);
    idle(1);
    clr_pulse();
    dchk("clr_bec", int'(BIT_ERR_CNT), 0);
    dchk("clr_wec", int'(WORD_ERR_CNT), 0);
    dchk("clr_wc", int'(WORD_CNT), 0);
    dchk("clr_lk", int'(LOCKED), 1);
    word(16'h0003, 0);
    idle(2);
    dchk("clr_next_bec", int'(BIT_ERR_CNT), 2);

    // random traffic in phases of varying error density
    for (int ph = 0; ph < 20; ph++) begin
      int pe;
      case (ph % 4)
        0: pe = 0;
        1: pe = 2;
        2: pe = 30;
        default: pe = 8;
      endcase
      for (int i = 0; i < 200; i++) begin
        RST = ($urandom_range(999) < 3);
        CLR = ($urandom_range(99) < 1);
        EN  = ($urandom_range(99) < 75);
        if ($urandom_range(99) < pe)
          ERR_IN = ($urandom_range(1) == 1) ? NB'($urandom)
                 : NB'(1) << $urandom_range(NB - 1);
        else
          ERR_IN = '0;
        step();
      end
    end
    RST = 0;
    CLR = 0;
    idle(3);

    @(negedge CLK);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gtfraw_vnc_prbs_err_mon.md
# gtfraw_vnc_prbs_err_mon

Error monitor directly downstream of the PRBS checker in the GTF raw-mode latency design. It consumes the checker's per-word XOR error vector, where all-zero means the word matched the expected sequence. It runs a lock/loss state machine and keeps saturating counters of compared words, errored words, bit errors and lock losses for status readout. All logic is in the CLK domain; there is no CDC.

## Interface
Parameters:
- NBITS, 16, width of the error vector; must equal the checker's NBITS.
- LOCK_CNT, 64, consecutive clean words needed to enter LOCKED (range 1..65535).
- UNLOCK_CNT, 4, consecutive errored words that drop LOCKED (range 1..65535).
- CNT_W, 32, width of every statistics counter.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- ERR_IN  in  NBITS  error vector from the checker; bit=1 means bit mismatch.
- EN  in  1  ERR_IN valid qualifier; words with EN=0 are ignored entirely.
- CLR  in  1  synchronous clear of the statistics counters; does not affect the FSM.
- LOCKED  out  1  high while the FSM is in LOCKED.
- LOCK_LOST  out  1  one-cycle pulse on the LOCKED->SEARCH transition.
- WORD_CNT  out  CNT_W  valid words processed while LOCKED.
- WORD_ERR_CNT  out  CNT_W  words with any bit set while LOCKED.
- BIT_ERR_CNT  out  CNT_W  total set bits while LOCKED.
- LOSS_CNT  out  CNT_W  number of LOCKED->SEARCH transitions.

## Operation
Pipeline:
- S0 registers ERR_IN and EN.
- S1 registers the popcount of the S0 word (width clog2(NBITS+1)), the flag err = |word, and the valid bit.
- S2 updates the FSM, the run counters and the statistics counters.

FSM, two states; it only advances on words with valid=1:
- SEARCH: clean_run increments on clean words and resets to 0 on errored words. When a clean word brings clean_run to LOCK_CNT, go to LOCKED and clear clean_run.
- LOCKED: err_run increments on errored words and resets to 0 on clean words. When an errored word brings err_run to UNLOCK_CNT, go to SEARCH, clear err_run, pulse LOCK_LOST and increment LOSS_CNT.

Statistics while LOCKED (including the word that causes loss of lock):
- Each valid word adds 1 to WORD_CNT.
- An errored word adds 1 to WORD_ERR_CNT and adds its popcount to BIT_ERR_CNT.
- Words in SEARCH, including the word completing the lock, are not counted.

Arithmetic and counter rules:
- Every counter saturates at 2^CNT_W-1 and never wraps.
- The BIT_ERR_CNT add is saturating: if the sum overflows, the result is all-ones.
- Run counters are 16-bit and saturate.

Boundary conditions:
- EN=0 words hold every counter and the FSM unchanged. Gaps in EN do not break a consecutive run.
- CLR takes priority over any increment in the same S2 cycle: the counter becomes 0 and that word is not counted. Words already in S0/S1 are counted normally after CLR.
- CLR while LOCKED leaves LOCKED=1. CLR coincident with a loss of lock: LOSS_CNT=0, and LOCK_LOST still pulses.
- RST at any point returns the FSM to SEARCH and sets both run counters to 0. It also zeroes all pipeline valids and all outputs, discarding in-flight words.

## Timing
- Reset values: LOCKED=0, LOCK_LOST=0, all counters 0, state SEARCH.
- Latency: a word sampled with EN=1 at clock edge k is reflected in LOCKED, LOCK_LOST and all counters after edge k+2.
- LOCK_LOST is high for exactly the one cycle following the transitioning edge.
- Throughput is one word per CLK, with no back-pressure.
- All outputs are registered.

## Test plan
- Reset: assert RST for 4 cycles mid-traffic. All outputs read 0 and the state is SEARCH, then 64 clean words are needed to lock again.
- Lock acquisition (NBITS=16, LOCK_CNT=64):
  - 64 clean words with EN=1: LOCKED rises after edge 66 counting the first sample edge as 1, and all counters stay 0.
  - 63 clean words, then 16'h0001, then 64 clean words: LOCKED stays 0 until the 128th word.
  - BIT_ERR_CNT stays 0 in both cases.
- Counting while locked:
  - Send 16'h0101, then 10 clean words.
  - Required: WORD_CNT=11, WORD_ERR_CNT=1, BIT_ERR_CNT=2, LOCKED=1.
  - Insert EN=0 gaps of 3 cycles between words; the same values result.
- Loss of lock (UNLOCK_CNT=4):
  - Three 16'hFFFF words, a clean word, then four 16'hFFFF words.
  - Required: a single LOCK_LOST pulse after the 8th word, LOCKED=0, LOSS_CNT=1, WORD_ERR_CNT=7, BIT_ERR_CNT=112.
- Saturation (CNT_W=8, UNLOCK_CNT=1000):
  - 20 words of 16'hFFFF while locked.
  - Required: BIT_ERR_CNT=255 after the 16th word and holds at 255; WORD_ERR_CNT=20.
- CLR priority:
  - Assert CLR in the S2 cycle of an errored word 16'h000F while locked.
  - Required: all counters read 0, LOCKED=1, and the next word 16'h0003 gives BIT_ERR_CNT=2.
